uart_rx_sampler: RTL and testbench



---
 rtl/uart_rx_sampler_pkg.sv | 8 +
 rtl/uart_rx_sampler_if.sv | 19 +
 rtl/uart_rx_sampler_bit_sync.sv | 19 +
 rtl/uart_rx_sampler.sv | 112 +++++++++++
 tb/tb_uart_rx_sampler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_sampler_pkg.sv
// uart_pkg: FSM states, divisor floor and register bit indices shared with the UART register block
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
  localparam int MIN_CPB = 4;
  localparam int CTRL_RX_EN = 0;
  localparam int STAT_BREAK = 1;
  localparam int STAT_RXVALID = 2;
endpackage

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: receive-side line, control and status signals between the sampler and the register block
interface uart_rx_sampler_if #(parameter int CPB_WIDTH = 32, parameter int CNT_WIDTH = 32);
  logic                 uart_rxd;
  logic                 uart_rx_en;
  logic [CPB_WIDTH-1:0] cycles_per_bit;
  logic                 uart_rx_valid;
  logic [7:0]           uart_rx_data;
  logic                 uart_rx_break;
  logic                 uart_rx_frame_err;
  logic [CNT_WIDTH-1:0] uart_rx_char_count;
  modport master (
    input  uart_rxd, uart_rx_en, cycles_per_bit,
    output uart_rx_valid, uart_rx_data, uart_rx_break, uart_rx_frame_err, uart_rx_char_count
  );
  modport slave (
    output uart_rxd, uart_rx_en, cycles_per_bit,
    input  uart_rx_valid, uart_rx_data, uart_rx_break, uart_rx_frame_err, uart_rx_char_count
  );
endinterface

// File: rtl/uart_rx_sampler_bit_sync.sv
// bit_sync: two-flop synchroniser for an asynchronous input pin, with a selectable reset level
module bit_sync #(parameter logic RST_VAL = 1'b1) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 receive front end; mid-bit sampling, break/framing detection and character count
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CPB_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic resetn,
  uart_rx_sampler_if.master bus
);
  logic                 rxs, tick;
  state_e               state_q, state_d;
  logic [CPB_WIDTH-1:0] cpb_q, cpb_d, timer_q, timer_d, cpb_in;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d, brk_q, brk_d, ferr_q, ferr_d, armed_q, armed_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  bit_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(resetn), .d(bus.uart_rxd), .q(rxs));

  assign cpb_in = bus.cycles_per_bit < CPB_WIDTH'(MIN_CPB) ? CPB_WIDTH'(MIN_CPB) : bus.cycles_per_bit;
  assign tick   = timer_q == '0;

  always_comb begin
    state_d = state_q;
    cpb_d   = cpb_q;
    timer_d = tick ? timer_q : timer_q - 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = brk_q;
    cnt_d   = cnt_q;
    // a start is only honoured once the line has been seen idle-high since enable
    armed_d = bus.uart_rx_en & (armed_q | rxs);
    if (!bus.uart_rx_en) begin
      state_d = IDLE;
      brk_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!rxs && armed_q) begin
          cpb_d   = cpb_in;
          timer_d = (cpb_in >> 1) - 1'b1;
          state_d = START;
        end
        START: if (tick) begin
          state_d = rxs ? IDLE : DATA;
          timer_d = cpb_q - 1'b1;
          idx_d   = '0;
        end
        DATA: if (tick) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          timer_d = cpb_q - 1'b1;
          state_d = idx_q == 4'(DATA_BITS - 1) ? STOP : DATA;
        end
        STOP: if (tick) begin
          // a low stop bit always parks in BREAK so the low line cannot look like a new start
          state_d = rxs ? IDLE : BREAK;
          valid_d = rxs;
          data_d  = rxs ? 8'(shift_q) : data_q;
          cnt_d   = cnt_q + CNT_WIDTH'(rxs);
          brk_d   = !rxs && shift_q == '0;
          ferr_d  = !rxs && shift_q != '0;
        end
        BREAK: if (rxs) begin
          brk_d   = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cpb_q   <= '0;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cpb_q   <= cpb_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      brk_q   <= brk_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.uart_rx_valid      = valid_q;
  assign bus.uart_rx_data       = data_q;
  assign bus.uart_rx_break      = brk_q;
  assign bus.uart_rx_frame_err  = ferr_q;
  assign bus.uart_rx_char_count = cnt_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: frame table, hand-written corner sequences and random frames against a frame-level model
module tb_uart_rx_sampler;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uart_rx_sampler_if #(.CPB_WIDTH(32), .CNT_WIDTH(4)) bus ();
  uart_rx_sampler #(.DATA_BITS(8), .CPB_WIDTH(32), .CNT_WIDTH(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic [31:0] cpb;
    logic [7:0]  data;
    logic        stop;
    logic        ev;
    logic        ef;
    logic        eb;
  } vec_t;

  int checks = 0, errors = 0;
  int cyc = 0, nv = 0, nf = 0, nb = 0, dbl = 0, last_vcyc = 0;
  logic prev_v = 1'b0;
  logic [7:0] vq[$];
  logic [7:0] exp_data = 8'h00;
  logic [3:0] exp_cnt = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.uart_rx_valid) begin
      nv++;
      vq.push_back(bus.uart_rx_data);
      last_vcyc = cyc;
      if (prev_v) dbl++;
    end
    prev_v = bus.uart_rx_valid;
    if (bus.uart_rx_frame_err) nf++;
    if (bus.uart_rx_break) nb++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int eff(input logic [31:0] c);
    return (c < 4) ? 4 : int'(c);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int n);
    bus.uart_rxd = b;
    wait_cyc(n);
  endtask

  task automatic send(input logic [31:0] c, input logic [7:0] d, input logic stop, input logic [31:0] later);
    int e;
    e = eff(c);
    bus.cycles_per_bit = c;
    drive_bit(1'b0, e);
    bus.cycles_per_bit = later;
    for (int i = 0; i < 8; i++) drive_bit(d[i], e);
    drive_bit(stop, e);
    bus.uart_rxd = 1'b1;
  endtask

  task automatic frame_check(input string tag, input logic [31:0] c, input logic [7:0] d, input logic stop,
                             input logic [31:0] later, input logic ev, input logic ef, input logic eb);
    int v0, f0, b0;
    v0 = nv; f0 = nf; b0 = nb;
    send(c, d, stop, later);
    wait_cyc(eff(c) + 8);
    if (ev) begin
      exp_data = d;
      exp_cnt  = exp_cnt + 4'd1;
    end
    chk({tag, " valid"}, nv - v0, {31'd0, ev});
    chk({tag, " ferr"}, nf - f0, {31'd0, ef});
    chk({tag, " brk"}, {31'd0, nb > b0}, {31'd0, eb});
    chk({tag, " data"}, {24'd0, bus.uart_rx_data}, {24'd0, exp_data});
    chk({tag, " count"}, {28'd0, bus.uart_rx_char_count}, {28'd0, exp_cnt});
  endtask

  vec_t tbl[8];

  initial begin
    int v0, f0, b0, q0, t0, lat;
    logic [31:0] c;
    logic [7:0] d;
    logic st;
    tbl[0] = '{32'd16, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{32'd16, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'd16, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{32'd1,  8'hC3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{32'd0,  8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'd7,  8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'd33, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{32'd4,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    bus.uart_rxd = 1'b1;
    bus.uart_rx_en = 1'b0;
    bus.cycles_per_bit = 32'd16;
    wait_cyc(3);
    chk("rst valid", {31'd0, bus.uart_rx_valid}, 32'd0);
    chk("rst data", {24'd0, bus.uart_rx_data}, 32'd0);
    chk("rst brk", {31'd0, bus.uart_rx_break}, 32'd0);
    chk("rst ferr", {31'd0, bus.uart_rx_frame_err}, 32'd0);
    chk("rst count", {28'd0, bus.uart_rx_char_count}, 32'd0);
    resetn = 1'b1;
    bus.uart_rx_en = 1'b1;
    wait_cyc(4);

    v0 = nv;
    t0 = cyc;
    send(32'd16, 8'h55, 1'b1, 32'd16);
    wait_cyc(16);
    exp_data = 8'h55;
    exp_cnt = exp_cnt + 4'd1;
    lat = last_vcyc - t0;
    chk("t1 valid", nv - v0, 32'd1);
    chk("t1 latency", {31'd0, lat >= 154 && lat <= 156}, 32'd1);
    chk("t1 data", {24'd0, bus.uart_rx_data}, {24'd0, exp_data});
    chk("t1 count", {28'd0, bus.uart_rx_char_count}, {28'd0, exp_cnt});

    v0 = nv; f0 = nf; b0 = nb;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 40);
    chk("glitch valid", nv - v0, 32'd0);
    chk("glitch ferr", nf - f0, 32'd0);
    chk("glitch brk", nb - b0, 32'd0);
    chk("glitch count", {28'd0, bus.uart_rx_char_count}, {28'd0, exp_cnt});
    frame_check("post glitch", 32'd16, 8'h96, 1'b1, 32'd16, 1'b1, 1'b0, 1'b0);

    v0 = nv; f0 = nf;
    drive_bit(1'b0, 12 * 16);
    chk("brk high", {31'd0, bus.uart_rx_break}, 32'd1);
    drive_bit(1'b1, 2);
    chk("brk held", {31'd0, bus.uart_rx_break}, 32'd1);
    wait_cyc(1);
    chk("brk clear", {31'd0, bus.uart_rx_break}, 32'd0);
    chk("brk valid", nv - v0, 32'd0);
    chk("brk ferr", nf - f0, 32'd0);
    frame_check("after brk", 32'd16, 8'h3C, 1'b1, 32'd16, 1'b1, 1'b0, 1'b0);

    v0 = nv;
    bus.cycles_per_bit = 32'd16;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 4 * 16 + 8);
    bus.uart_rx_en = 1'b0;
    drive_bit(1'b1, 8 + 3 * 16 + 16);
    bus.uart_rx_en = 1'b1;
    wait_cyc(16);
    frame_check("en abort", 32'd16, 8'h81, 1'b1, 32'd16, 1'b1, 1'b0, 1'b0);
    chk("en abort total", nv - v0, 32'd1);

    v0 = nv; f0 = nf; b0 = nb;
    bus.uart_rx_en = 1'b0;
    drive_bit(1'b0, 20);
    bus.uart_rx_en = 1'b1;
    drive_bit(1'b0, 48);
    drive_bit(1'b1, 20);
    frame_check("qualify", 32'd16, 8'h5A, 1'b1, 32'd16, 1'b1, 1'b0, 1'b0);
    chk("qualify total", nv - v0, 32'd1);
    chk("qualify ferr", nf - f0, 32'd0);
    chk("qualify brk", nb - b0, 32'd0);

    for (int i = 0; i < 8; i++)
      frame_check($sformatf("tbl%0d", i), tbl[i].cpb, tbl[i].data, tbl[i].stop, 32'd9,
                  tbl[i].ev, tbl[i].ef, tbl[i].eb);

    for (int i = 0; i < 30; i++) begin
      c = $urandom_range(0, 24);
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      st = $urandom_range(0, 4) != 0;
      frame_check($sformatf("rand%0d", i), c, d, st, $urandom_range(0, 40), st, !st && d != 0, !st && d == 0);
    end

    v0 = nv;
    q0 = vq.size();
    send(32'd1, 8'h00, 1'b1, 32'd1);
    send(32'd1, 8'hFF, 1'b1, 32'd1);
    send(32'd1, 8'h7E, 1'b1, 32'd1);
    wait_cyc(12);
    exp_cnt = exp_cnt + 4'd3;
    chk("b2b valids", nv - v0, 32'd3);
    chk("b2b byte0", {24'd0, vq[q0]}, 32'h00);
    chk("b2b byte1", {24'd0, vq[q0+1]}, 32'hFF);
    chk("b2b byte2", {24'd0, vq[q0+2]}, 32'h7E);
    chk("b2b count", {28'd0, bus.uart_rx_char_count}, {28'd0, exp_cnt});

    resetn = 1'b0;
    wait_cyc(2);
    chk("rst2 count", {28'd0, bus.uart_rx_char_count}, 32'd0);
    resetn = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < 15; i++) send(32'd4, 8'($urandom), 1'b1, 32'd4);
    wait_cyc(12);
    chk("count ones", {28'd0, bus.uart_rx_char_count}, 32'd15);
    send(32'd4, 8'h42, 1'b1, 32'd4);
    wait_cyc(12);
    chk("count wrap", {28'd0, bus.uart_rx_char_count}, 32'd0);
    chk("wrap data", {24'd0, bus.uart_rx_data}, 32'h42);
    chk("no double valid", dbl, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
